// File: rtl/pmodad1_rx.sv
// SPI read master for a dual 12-bit ADC pair (shared CS/SCLK), 24-bit sample-pair stream out.
// Optional leading-zero check enabled by defining PMODAD1_ZERO_CHECK_EN (adds frame_err).
//
// state | meaning
// IDLE  | cs high, waiting for start
// SETUP | cs low, sclk high for CLK_DIV cycles before the first bit
// SHIFT | 16 bit periods, sclk low then high, data captured on the rising edge
// QUIET | cs high for QUIET_CYC cycles before start is accepted again
module pmodad1_rx #(
    parameter int CLK_DIV   = 2,
    parameter int QUIET_CYC = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic [23:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        overrun,
    output logic        cs,
    output logic        sclk,
    input  logic        sdata0,
    input  logic        sdata1
`ifdef PMODAD1_ZERO_CHECK_EN
    ,
    output logic        frame_err
`endif
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

    localparam logic [7:0] DIV_LOAD   = 8'(CLK_DIV - 1);
    localparam logic [9:0] QUIET_LOAD = 10'(QUIET_CYC - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [9:0]  qcnt, qcnt_nxt;
    logic [3:0]  bit_idx, bit_idx_nxt;
    logic [11:0] sr0, sr0_nxt, sr1, sr1_nxt;
    logic        cs_nxt, sclk_nxt, busy_nxt, m_valid_nxt, overrun_nxt;
    logic [23:0] m_data_nxt;
`ifdef PMODAD1_ZERO_CHECK_EN
    logic        lead_err, lead_err_nxt, frame_err_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            qcnt    <= '0;
            bit_idx <= '0;
            sr0     <= '0;
            sr1     <= '0;
            cs      <= 1'b1;
            sclk    <= 1'b1;
            busy    <= 1'b0;
            m_data  <= '0;
            m_valid <= 1'b0;
            overrun <= 1'b0;
`ifdef PMODAD1_ZERO_CHECK_EN
            lead_err  <= 1'b0;
            frame_err <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            qcnt    <= qcnt_nxt;
            bit_idx <= bit_idx_nxt;
            sr0     <= sr0_nxt;
            sr1     <= sr1_nxt;
            cs      <= cs_nxt;
            sclk    <= sclk_nxt;
            busy    <= busy_nxt;
            m_data  <= m_data_nxt;
            m_valid <= m_valid_nxt;
            overrun <= overrun_nxt;
`ifdef PMODAD1_ZERO_CHECK_EN
            lead_err  <= lead_err_nxt;
            frame_err <= frame_err_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        qcnt_nxt    = qcnt;
        bit_idx_nxt = bit_idx;
        sr0_nxt     = sr0;
        sr1_nxt     = sr1;
        cs_nxt      = cs;
        sclk_nxt    = sclk;
        m_data_nxt  = m_data;
        m_valid_nxt = m_valid;
        overrun_nxt = 1'b0;
`ifdef PMODAD1_ZERO_CHECK_EN
        lead_err_nxt  = lead_err;
        frame_err_nxt = 1'b0;
`endif
        if (m_valid && m_ready)
            m_valid_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETUP;
                    cs_nxt    = 1'b0;
                    cnt_nxt   = DIV_LOAD;
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    state_nxt   = SHIFT;
                    sclk_nxt    = 1'b0;
                    cnt_nxt     = DIV_LOAD;
                    bit_idx_nxt = '0;
`ifdef PMODAD1_ZERO_CHECK_EN
                    lead_err_nxt = 1'b0;
`endif
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            SHIFT: begin
                if (cnt != 8'd0) begin
                    cnt_nxt = cnt - 8'd1;
                end else if (!sclk) begin
                    // 12-bit registers let the four leading bits fall off the top naturally
                    sclk_nxt = 1'b1;
                    cnt_nxt  = DIV_LOAD;
                    sr0_nxt  = {sr0[10:0], sdata0};
                    sr1_nxt  = {sr1[10:0], sdata1};
`ifdef PMODAD1_ZERO_CHECK_EN
                    if (bit_idx < 4'd4 && (sdata0 || sdata1))
                        lead_err_nxt = 1'b1;
`endif
                end else if (bit_idx == 4'd15) begin
                    state_nxt   = QUIET;
                    cs_nxt      = 1'b1;
                    qcnt_nxt    = QUIET_LOAD;
                    m_data_nxt  = {sr1, sr0};
                    m_valid_nxt = 1'b1;
                    overrun_nxt = m_valid && !m_ready;
`ifdef PMODAD1_ZERO_CHECK_EN
                    frame_err_nxt = lead_err;
`endif
                end else begin
                    sclk_nxt    = 1'b0;
                    cnt_nxt     = DIV_LOAD;
                    bit_idx_nxt = bit_idx + 4'd1;
                end
            end
            QUIET: begin
                if (qcnt == 10'd0)
                    state_nxt = IDLE;
                else
                    qcnt_nxt = qcnt - 10'd1;
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_pmodad1_rx.sv
// Directed bench for pmodad1_rx: ADC pair model, frame timing, stream handshake, gating, reset.
module tb_pmodad1_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic [23:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        overrun;
    logic        cs;
    logic        sclk;
    logic        sdata0 = 1'b0;
    logic        sdata1 = 1'b0;
`ifdef PMODAD1_ZERO_CHECK_EN
    logic        frame_err;
`endif

    pmodad1_rx #(.CLK_DIV(2), .QUIET_CYC(24)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .overrun (overrun),
        .cs      (cs),
        .sclk    (sclk),
        .sdata0  (sdata0),
        .sdata1  (sdata1)
`ifdef PMODAD1_ZERO_CHECK_EN
        ,
        .frame_err (frame_err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ADC pair: MSB driven on the first sclk fall after cs falls, next bit on each fall
    logic [15:0] frame0 = '0, frame1 = '0;
    int k = 0;
    always @(negedge cs) k = 0;
    always @(negedge sclk) begin
        if (!cs && k < 16) begin
            sdata0 = frame0[15-k];
            sdata1 = frame1[15-k];
            k++;
        end
    end

    // Monitors, sampled on the falling clk edge
    int cyc = 0;
    int cs_fall_q[$];
    int busy_low_cnt = 0, ovr_cnt = 0, ferr_cnt = 0, valid_cnt = 0;
    int sclk_falls = 0, sclk_low = 0, sclk_bad_w = 0, run_w = 0;
    logic prev_cs = 1'b1, prev_sclk = 1'b1;
    always @(negedge clk) begin
        cyc++;
        if (prev_cs && !cs) cs_fall_q.push_back(cyc);
        if (cs_fall_q.size() == 1 && !busy) busy_low_cnt++;
        if (overrun) ovr_cnt++;
        if (m_valid) valid_cnt++;
`ifdef PMODAD1_ZERO_CHECK_EN
        if (frame_err) ferr_cnt++;
`endif
        if (!cs) begin
            if (prev_sclk && !sclk) sclk_falls++;
            if (!sclk) begin
                sclk_low++;
                run_w++;
            end
        end
        if (sclk && !prev_sclk) begin
            if (run_w != 2) sclk_bad_w++;
            run_w = 0;
        end
        prev_cs   = cs;
        prev_sclk = sclk;
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Runs one frame and returns the number of falling-edge samples with cs low
    task automatic run_frame(input logic [15:0] f0, input logic [15:0] f1, output int low);
        frame0 = f0;
        frame1 = f1;
        pulse_start();
        low = 0;
        for (int i = 0; i < 400 && !cs; i++) begin
            low++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", n < 300, 1);
    endtask

    int low;
    bit v_prev;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cs", cs, 1);
        check("rst_sclk", sclk, 1);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic conversion
        sclk_falls = 0; sclk_low = 0; sclk_bad_w = 0;
        run_frame(16'h0AC3, 16'h05F0, low);
        check("basic_cs_low", low, 66);
        check("basic_sclk_pulses", sclk_falls, 16);
        check("basic_sclk_low_cyc", sclk_low, 32);
        check("basic_sclk_width", sclk_bad_w, 0);
        check("basic_valid_at_cs_rise", m_valid, 1);
        check("basic_data", m_data, 24'h5F0AC3);
        check("basic_busy_quiet", busy, 1);
        check("basic_no_overrun", ovr_cnt, 0);
        wait_idle();
        @(negedge clk) m_ready = 1'b1;
        @(negedge clk) m_ready = 1'b0;
        check("accept_clears_valid", m_valid, 0);

        // Backpressure and overrun
        run_frame(16'h0111, 16'h0222, low);
        check("bp1_data", m_data, 24'h222111);
        check("bp1_no_overrun", ovr_cnt, 0);
        wait_idle();
        run_frame(16'h0333, 16'h0444, low);
        repeat (3) @(negedge clk);
        check("bp2_data", m_data, 24'h444333);
        check("bp2_valid", m_valid, 1);
        check("bp2_overrun_1cyc", ovr_cnt, 1);
        @(negedge clk) m_ready = 1'b1;
        @(negedge clk) m_ready = 1'b0;
        check("bp_release_valid", m_valid, 0);
        wait_idle();

        // Accept on the same edge a new pair loads
        run_frame(16'h0555, 16'h0666, low);
        wait_idle();
        ovr_cnt = 0;
        frame0 = 16'h0777;
        frame1 = 16'h0888;
        pulse_start();
        repeat (65) @(negedge clk);
        check("sim_hold_valid", m_valid, 1);
        check("sim_hold_data", m_data, 24'h666555);
        m_ready = 1'b1;
        @(negedge clk) m_ready = 1'b0;
        check("sim_valid", m_valid, 1);
        check("sim_data", m_data, 24'h888777);
        check("sim_no_overrun", ovr_cnt, 0);
        m_ready = 1'b1;
        wait_idle();

        // Start held high: frames back to back at minimum spacing
        cs_fall_q.delete();
        busy_low_cnt = 0;
        @(negedge clk) start = 1'b1;
        repeat (3 * 91 + 5) @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("gate_frames", cs_fall_q.size(), 4);
        if (cs_fall_q.size() >= 3) begin
            check("gate_spacing_1", cs_fall_q[1] - cs_fall_q[0], 91);
            check("gate_spacing_2", cs_fall_q[2] - cs_fall_q[1], 91);
        end
        check("gate_busy_low", busy_low_cnt, 1);

        // Start during QUIET is dropped
        run_frame(16'h0123, 16'h0456, low);
        cs_fall_q.delete();
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (100) @(negedge clk);
        check("quiet_start_ignored", cs_fall_q.size(), 0);
        check("quiet_idle", busy, 0);

        // Asynchronous reset in bit 7
        frame0 = 16'h0FFF;
        frame1 = 16'h0FFF;
        pulse_start();
        repeat (31) @(negedge clk);
        check("ar_in_frame", cs, 0);
        #1 rst = 1'b1;
        #1;
        check("ar_cs", cs, 1);
        check("ar_sclk", sclk, 1);
        check("ar_busy", busy, 0);
        check("ar_valid", m_valid, 0);
        @(negedge clk) rst = 1'b0;
        valid_cnt = 0;
        repeat (100) @(negedge clk);
        check("ar_no_valid", valid_cnt, 0);
        run_frame(16'h0ABC, 16'h0DEF, low);
        check("ar_next_cs_low", low, 66);
        check("ar_next_data", m_data, 24'hDEFABC);
        wait_idle();

`ifdef PMODAD1_ZERO_CHECK_EN
        ferr_cnt = 0;
        run_frame(16'h0000, 16'h8123, low);
        repeat (3) @(negedge clk);
        check("zc_data_hi", m_data[23:12], 12'h123);
        check("zc_err_pulse", ferr_cnt, 1);
        wait_idle();
        ferr_cnt = 0;
        run_frame(16'h0000, 16'h0123, low);
        repeat (3) @(negedge clk);
        check("zc_clean_data", m_data[23:12], 12'h123);
        check("zc_clean_err", ferr_cnt, 0);
        wait_idle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
